kronos_wb: RTL

KRONOS_WB -- requirements
Module: kronos_wb

---
 rtl/kronos_wb.sv | 106 ++++++++++
 1 files changed

// File: rtl/kronos_wb.sv
// Kronos write-back stage: commits ALU results and performs data-bus loads
// with byte/half extraction before writing the register file.
module kronos_wb (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] execute_result,
  input  logic [4:0]  execute_rd,
  input  logic        execute_rd_write,
  input  logic        execute_is_load,
  input  logic [1:0]  execute_size,
  input  logic        execute_uns,
  input  logic        execute_vld,
  output logic        execute_rdy,
  output logic [31:0] data_addr,
  output logic        data_req,
  input  logic        data_ack,
  input  logic [31:0] data_rd_data,
  output logic [31:0] regwr_data,
  output logic [4:0]  regwr_sel,
  output logic        regwr_en,
  output logic        regwr_pending
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        rd_ok;
  logic        wr_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_val;

  assign accept = execute_vld && execute_rdy;
  assign rd_ok  = execute_rd_write && (execute_rd != 5'd0);

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    execute_rdy   = (state != LOAD);
    data_req      = (state == LOAD);
    regwr_en      = (state == WRITE) && wr_q;
    regwr_pending = (state != IDLE) && wr_q;
    case (state)
      LOAD: begin
        if (data_ack) state_nxt = WRITE;
      end
      IDLE, WRITE: begin
        if (accept) state_nxt = execute_is_load ? LOAD : WRITE;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane extraction; the execute stage guarantees natural alignment.
  always_comb begin
    byte_val = 8'h00;
    half_val = off_q[1] ? data_rd_data[31:16] : data_rd_data[15:0];
    load_val = data_rd_data;
    case (off_q)
      2'd0:    byte_val = data_rd_data[7:0];
      2'd1:    byte_val = data_rd_data[15:8];
      2'd2:    byte_val = data_rd_data[23:16];
      default: byte_val = data_rd_data[31:24];
    endcase
    case (size_q)
      2'b00:   load_val = {{24{byte_val[7] & ~uns_q}}, byte_val};
      2'b01:   load_val = {{16{half_val[15] & ~uns_q}}, half_val};
      default: load_val = data_rd_data;
    endcase
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      regwr_data <= 32'd0;
      regwr_sel  <= 5'd0;
      data_addr  <= 32'd0;
      wr_q       <= 1'b0;
      off_q      <= 2'd0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
    end else if (accept) begin
      regwr_sel <= execute_rd;
      wr_q      <= rd_ok;
      if (execute_is_load) begin
        data_addr <= {execute_result[31:2], 2'b00};
        off_q     <= execute_result[1:0];
        size_q    <= execute_size;
        uns_q     <= execute_uns;
      end else begin
        regwr_data <= execute_result;
      end
    end else if ((state == LOAD) && data_ack) begin
      regwr_data <= load_val;
    end
  end

endmodule
